divide_sequencer: RTL and testbench

Control stage directly upstream of the signed iterative divider. It accepts division requests over a valid/ready handshake, buffers one pending request and issues single-cycle start pulses to the divider. It waits on the divider's ready, then captures quotient and remainder into a held result port with its own valid/ready handshake. It owns fault reporting (divide-by-zero, watchdog timeout) so consumers never see the divider's sticky fault flag or its unreset outputs.

---
 rtl/divide_sequencer_if.sv | 53 +++++
 rtl/divide_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_divide_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divide_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : divide_sequencer_if
// Description : Request, divider-side and result-side signals of the
//               divide sequencer. The master modport is the sequencer's view.
//               The slave modport is the view of the attached
//               requester/divider/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface divide_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             request_valid;
    logic             request_ready;
    logic [WIDTH-1:0] request_dividend;
    logic [WIDTH-1:0] request_divisor;

    logic             divider_start;
    logic [WIDTH-1:0] divider_dividend;
    logic [WIDTH-1:0] divider_divisor;
    logic [WIDTH-1:0] divider_quotient;
    logic [WIDTH-1:0] divider_remainder;
    logic             divider_ready;

    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_quotient;
    logic [WIDTH-1:0] result_remainder;
    logic [1:0]       result_fault;

    logic             busy;

    modport master (
        input  request_valid, request_dividend, request_divisor,
        input  divider_quotient, divider_remainder, divider_ready,
        input  result_ready,
        output request_ready,
        output divider_start, divider_dividend, divider_divisor,
        output result_valid, result_quotient, result_remainder, result_fault,
        output busy
    );

    modport slave (
        output request_valid, request_dividend, request_divisor,
        output divider_quotient, divider_remainder, divider_ready,
        output result_ready,
        input  request_ready,
        input  divider_start, divider_dividend, divider_divisor,
        input  result_valid, result_quotient, result_remainder, result_fault,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/divide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : divide_sequencer
// Description : Control stage in front of the signed iterative divider.
//               It buffers one request and pulses the divider's start.
//               It captures the divider output into a held result port.
//               It reports divide-by-zero and watchdog timeout faults.
// Revision    : 1.0 - initial release
// ============================================================================
module divide_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = WIDTH + 4
) (
    input  wire logic            clock,
    input  wire logic            reset,
    divide_sequencer_if.master   bus
);

    localparam int                  c_WD_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_WIDTH-1:0] c_WD_LAST = c_WD_WIDTH'(TIMEOUT - 1);
    localparam logic [c_WD_WIDTH-1:0] c_WD_ONE  = c_WD_WIDTH'(1);

    localparam logic [1:0] c_FAULT_NONE    = 2'b00;
    localparam logic [1:0] c_FAULT_ZERO    = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_FAULT  = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_pend_full;
    logic [WIDTH-1:0] r_pend_dividend;
    logic [WIDTH-1:0] r_pend_divisor;

    logic [WIDTH-1:0] r_div_dividend;
    logic [WIDTH-1:0] r_div_divisor;
    logic [c_WD_WIDTH-1:0] r_wd;

    logic             r_result_valid;
    logic [WIDTH-1:0] r_result_quotient;
    logic [WIDTH-1:0] r_result_remainder;
    logic [1:0]       r_result_fault;

    logic             w_accept;
    logic             w_pend_zero;
    logic             w_pop;
    logic             w_issue;
    logic             w_capture;
    logic             w_timeout;
    logic             w_zero_fault;
    logic             w_consume;

    // The slot only takes a request when empty, so a pop and a push can never coincide.
    assign w_accept    = bus.request_valid && !r_pend_full;
    assign w_pend_zero = (r_pend_divisor == '0);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and datapath strobes. HOLD can chain straight into the next ISSUE/FAULT.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_zero_fault = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_full) begin
                    w_pop = 1'b1;
                    if (w_pend_zero) begin
                        w_state_next = S_FAULT;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE:  w_state_next = S_SETTLE;
            // The divider's ready reacts to start on the SETTLE edge, so it is ignored here.
            S_SETTLE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (bus.divider_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_FAULT: begin
                w_zero_fault = 1'b1;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (bus.result_ready) begin
                    w_consume = 1'b1;
                    if (r_pend_full) begin
                        w_pop = 1'b1;
                        if (w_pend_zero) begin
                            w_state_next = S_FAULT;
                        end else begin
                            w_issue      = 1'b1;
                            w_state_next = S_ISSUE;
                        end
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-entry pending request slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_full     <= 1'b0;
            r_pend_dividend <= '0;
            r_pend_divisor  <= '0;
        end else if (w_accept) begin
            r_pend_full     <= 1'b1;
            r_pend_dividend <= bus.request_dividend;
            r_pend_divisor  <= bus.request_divisor;
        end else if (w_pop) begin
            r_pend_full     <= 1'b0;
        end
    end

    // Divider operands are held from ISSUE until the next issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
        end else if (w_issue) begin
            r_div_dividend <= r_pend_dividend;
            r_div_divisor  <= r_pend_divisor;
        end
    end

    // Watchdog counts WAIT cycles. It is cleared while settling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   r_wd <= '0;
        else if (r_state == S_SETTLE) r_wd <= '0;
        else if (r_state == S_WAIT)   r_wd <= r_wd + c_WD_ONE;
    end

    // Result port: load on completion or fault. Drop valid when the consumer takes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result_valid     <= 1'b0;
            r_result_quotient  <= '0;
            r_result_remainder <= '0;
            r_result_fault     <= c_FAULT_NONE;
        end else if (w_capture) begin
            r_result_valid     <= 1'b1;
            r_result_quotient  <= bus.divider_quotient;
            r_result_remainder <= bus.divider_remainder;
            r_result_fault     <= c_FAULT_NONE;
        end else if (w_timeout || w_zero_fault) begin
            r_result_valid     <= 1'b1;
            r_result_quotient  <= '0;
            r_result_remainder <= '0;
            r_result_fault     <= w_timeout ? c_FAULT_TIMEOUT : c_FAULT_ZERO;
        end else if (w_consume) begin
            r_result_valid     <= 1'b0;
        end
    end

    assign bus.request_ready     = !r_pend_full;
    assign bus.divider_start     = (r_state == S_ISSUE);
    assign bus.divider_dividend  = r_div_dividend;
    assign bus.divider_divisor   = r_div_divisor;
    assign bus.result_valid      = r_result_valid;
    assign bus.result_quotient   = r_result_quotient;
    assign bus.result_remainder  = r_result_remainder;
    assign bus.result_fault      = r_result_fault;
    assign bus.busy              = (r_state != S_IDLE) || r_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_divide_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_divide_sequencer
// Description : Self-checking bench for divide_sequencer. A divider stub
//               supplies a chosen latency per issue. A queue-based scoreboard
//               predicts every result from the request operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divide_sequencer;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = WIDTH + 4;
    localparam int STUCK   = 1000;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [1:0]       f;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } ops_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    divide_sequencer_if #(.WIDTH(WIDTH)) bus ();

    divide_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    ops_t issue_q[$];
    int   lat_q[$];
    int   outstanding = 0;
    int   n_starts    = 0;
    int   next_lat    = 0;
    bit   rand_lat    = 1'b0;
    bit   rand_done   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Signed truncating division, the reference for both stub and scoreboard.
    function automatic logic [WIDTH-1:0] div_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int ia, ib, q;
        ia = int'($signed(a));
        ib = int'($signed(b));
        q  = ia / ib;
        return q[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] div_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int ia, ib, r;
        ia = int'($signed(a));
        ib = int'($signed(b));
        r  = ia % ib;
        return r[WIDTH-1:0];
    endfunction

    // Divider stub: ready rises L edges after the start edge.
    // Its outputs hold junk until then.
    initial begin : stub
        logic             s_start;
        logic [WIDTH-1:0] s_a, s_b, s_q, s_r;
        int               cnt;
        int               lat;
        cnt = 0;
        s_q = '0;
        s_r = '0;
        bus.divider_ready     = 1'b1;
        bus.divider_quotient  = '0;
        bus.divider_remainder = '0;
        forever begin
            @(negedge clock);
            s_start = bus.divider_start;
            s_a     = bus.divider_dividend;
            s_b     = bus.divider_divisor;
            @(posedge clock);
            if (s_start) begin
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                s_q = (s_b != '0) ? div_q(s_a, s_b) : '0;
                s_r = (s_b != '0) ? div_r(s_a, s_b) : '0;
                if (lat == 0) begin
                    bus.divider_ready     <= 1'b1;
                    bus.divider_quotient  <= s_q;
                    bus.divider_remainder <= s_r;
                    cnt = 0;
                end else begin
                    bus.divider_ready     <= 1'b0;
                    bus.divider_quotient  <= WIDTH'($urandom);
                    bus.divider_remainder <= WIDTH'($urandom);
                    cnt = lat;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.divider_ready     <= 1'b1;
                    bus.divider_quotient  <= s_q;
                    bus.divider_remainder <= s_r;
                end
            end
        end
    end

    // Compare process: occupancy, start pulses, result order/content and hold stability.
    initial begin : monitor
        bit               prev_hold, prev_start;
        logic [WIDTH-1:0] pq, pr, a, b;
        logic [1:0]       pf;
        exp_t             e;
        ops_t             o;
        int               lat;
        prev_hold  = 1'b0;
        prev_start = 1'b0;
        pq = '0; pr = '0; pf = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                issue_q.delete();
                lat_q.delete();
                outstanding = 0;
                prev_hold   = 1'b0;
                prev_start  = 1'b0;
            end else begin
                check("busy", int'(bus.busy), int'(outstanding != 0));
                if (outstanding == 0) check("request_ready_empty", int'(bus.request_ready), 1);
                if (outstanding == 2) check("request_ready_full", int'(bus.request_ready), 0);
                if (prev_hold) begin
                    check("hold_valid", int'(bus.result_valid), 1);
                    check("hold_quotient", int'(bus.result_quotient), int'(pq));
                    check("hold_remainder", int'(bus.result_remainder), int'(pr));
                    check("hold_fault", int'(bus.result_fault), int'(pf));
                end
                if (bus.divider_start) begin
                    n_starts++;
                    check("start_single_cycle", int'(prev_start), 0);
                    if (issue_q.size() == 0) begin
                        check("start_unexpected", 1, 0);
                    end else begin
                        o = issue_q.pop_front();
                        check("divider_dividend", int'(bus.divider_dividend), int'(o.a));
                        check("divider_divisor", int'(bus.divider_divisor), int'(o.b));
                    end
                end
                if (bus.result_valid && bus.result_ready) begin
                    if (exp_q.size() == 0) begin
                        check("result_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_quotient", int'(bus.result_quotient), int'(e.q));
                        check("result_remainder", int'(bus.result_remainder), int'(e.r));
                        check("result_fault", int'(bus.result_fault), int'(e.f));
                    end
                    outstanding--;
                end
                if (bus.request_valid && bus.request_ready) begin
                    a = bus.request_dividend;
                    b = bus.request_divisor;
                    if (b == '0) begin
                        e.q = '0; e.r = '0; e.f = 2'b01;
                    end else begin
                        lat = rand_lat ? int'($urandom_range(0, TIMEOUT + 2)) : next_lat;
                        lat_q.push_back(lat);
                        o.a = a; o.b = b;
                        issue_q.push_back(o);
                        if (lat > TIMEOUT) begin
                            e.q = '0; e.r = '0; e.f = 2'b10;
                        end else begin
                            e.q = div_q(a, b); e.r = div_r(a, b); e.f = 2'b00;
                        end
                    end
                    exp_q.push_back(e);
                    outstanding++;
                end
                prev_hold  = bus.result_valid && !bus.result_ready;
                prev_start = bus.divider_start;
                pq = bus.result_quotient;
                pr = bus.result_remainder;
                pf = bus.result_fault;
            end
        end
    end

    task automatic do_request(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int acc);
        acc = cyc;
        @(posedge clock);
        #1;
        bus.request_valid    = 1'b1;
        bus.request_dividend = a;
        bus.request_divisor  = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.request_ready) begin
                @(posedge clock);
                #1;
                acc = cyc;
                bus.request_valid = 1'b0;
                return;
            end
        end
        bus.request_valid = 1'b0;
        check("request_accept_timeout", 1, 0);
    endtask

    task automatic wait_result(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.result_valid) begin
                lat = cyc - acc;
                return;
            end
        end
        check("result_wait_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (outstanding == 0 && !bus.result_valid) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int acc, lat, s0;
        logic [WIDTH-1:0] ra, rb;
        bus.request_valid    = 1'b0;
        bus.request_dividend = '0;
        bus.request_divisor  = '0;
        bus.result_ready     = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_valid", int'(bus.result_valid), 0);
        check("reset_quotient", int'(bus.result_quotient), 0);
        check("reset_fault", int'(bus.result_fault), 0);
        check("reset_start", int'(bus.divider_start), 0);
        check("reset_div_dividend", int'(bus.divider_dividend), 0);
        check("reset_busy", int'(bus.busy), 0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", int'(bus.request_ready), 1);

        // 7/2 on the fast path
        next_lat = 0;
        s0 = n_starts;
        do_request(4'd7, 4'd2, acc);
        wait_result(acc, lat);
        check("t1_latency", lat, 4);
        check("t1_quotient", int'(bus.result_quotient), 3);
        check("t1_remainder", int'(bus.result_remainder), 1);
        check("t1_fault", int'(bus.result_fault), 0);
        @(negedge clock);
        check("t1_valid_one_cycle", int'(bus.result_valid), 0);
        check("t1_one_start", n_starts - s0, 1);

        // 6/3 with a full-length divide
        next_lat = WIDTH;
        do_request(4'd6, 4'd3, acc);
        wait_result(acc, lat);
        check("t2_latency", lat, WIDTH + 3);
        check("t2_quotient", int'(bus.result_quotient), 2);
        check("t2_remainder", int'(bus.result_remainder), 0);

        // 5/0 faults without a start, then 4/1 is clean
        wait_idle();
        s0 = n_starts;
        do_request(4'd5, 4'd0, acc);
        wait_result(acc, lat);
        check("t3_latency", lat, 2);
        check("t3_quotient", int'(bus.result_quotient), 0);
        check("t3_fault", int'(bus.result_fault), 1);
        @(negedge clock);
        check("t3_no_start", n_starts - s0, 0);
        next_lat = 0;
        do_request(4'd4, 4'd1, acc);
        wait_result(acc, lat);
        check("t3b_quotient", int'(bus.result_quotient), 4);
        check("t3b_remainder", int'(bus.result_remainder), 0);
        check("t3b_fault", int'(bus.result_fault), 0);

        // Back-to-back with a stalled consumer
        wait_idle();
        next_lat = 1;
        bus.result_ready = 1'b0;
        do_request(4'd7, 4'd2, acc);
        do_request(4'd6, 4'd3, acc);
        @(negedge clock);
        check("t4_ready_low", int'(bus.request_ready), 0);
        fork
            begin
                int acc3;
                do_request(4'd1, 4'd2, acc3);
            end
            begin
                repeat (20) @(posedge clock);
                @(negedge clock);
                check("t4_held_valid", int'(bus.result_valid), 1);
                check("t4_held_quotient", int'(bus.result_quotient), 3);
                check("t4_held_remainder", int'(bus.result_remainder), 1);
                @(posedge clock);
                #1 bus.result_ready = 1'b1;
            end
        join
        wait_idle();

        // Divider never answers: watchdog timeout
        next_lat = STUCK;
        do_request(4'd7, 4'd3, acc);
        wait_result(acc, lat);
        check("t5_latency", lat, 3 + TIMEOUT);
        check("t5_quotient", int'(bus.result_quotient), 0);
        check("t5_remainder", int'(bus.result_remainder), 0);
        check("t5_fault", int'(bus.result_fault), 2);
        @(negedge clock);
        check("t5_idle", int'(bus.busy), 0);

        // Asynchronous reset while in WAIT
        next_lat = WIDTH + 2;
        do_request(4'd6, 4'd3, acc);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_valid", int'(bus.result_valid), 0);
        check("t6_start", int'(bus.divider_start), 0);
        check("t6_div_dividend", int'(bus.divider_dividend), 0);
        check("t6_div_divisor", int'(bus.divider_divisor), 0);
        check("t6_busy", int'(bus.busy), 0);
        check("t6_fault", int'(bus.result_fault), 0);
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        next_lat = 0;
        do_request(4'd4, 4'd1, acc);
        wait_result(acc, lat);
        check("t6_after_latency", lat, 4);
        check("t6_after_quotient", int'(bus.result_quotient), 4);
        wait_idle();

        // Randomised traffic
        rand_lat  = 1'b1;
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clock);
                    ra = WIDTH'($urandom);
                    rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
                    do_request(ra, rb, acc);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1 bus.result_ready = ($urandom_range(0, 3) != 0);
                end
                bus.result_ready = 1'b1;
            end
        join
        wait_idle();
        check("end_results_drained", exp_q.size(), 0);
        check("end_issues_drained", issue_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
